// File: rtl/mod_pll_ctrl_pkg.sv
// Shared types and helpers for the PLL sequencing controller.
package mod_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_t;

  // One counter serves every timed state, so it is sized for the longest interval.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/mod_sync_2ff.sv
// Two-flop synchroniser with asynchronous active-low reset.
module mod_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mod_pll_ctrl.sv
// PLL start-up sequencer on the reference clock: reset, wait for lock,
// qualify lock stability, release system reset, retry or fault on failure.
module mod_pll_ctrl
  import mod_pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_pll_locked,
  input  logic                               i_soft_rst,
  output logic                               o_pll_resetb,
  output logic                               o_sys_rst_n,
  output logic [2:0]                         o_state,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   o_retry_cnt,
  output logic                               o_fault,
  output logic                               o_lock_lost
);

  localparam int CNT_W   = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  pll_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry_cnt, retry_nxt;
  logic               lock_s;
  logic               pll_resetb_d, sys_rst_n_d, fault_d, lock_lost_d;

  mod_sync_2ff u_lock_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (i_pll_locked),
    .q     (lock_s)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= PLL_RST;
      retry_cnt    <= '0;
      o_pll_resetb <= 1'b0;
      o_sys_rst_n  <= 1'b0;
      o_fault      <= 1'b0;
      o_lock_lost  <= 1'b0;
    end else begin
      state        <= state_nxt;
      retry_cnt    <= retry_nxt;
      o_pll_resetb <= pll_resetb_d;
      o_sys_rst_n  <= sys_rst_n_d;
      o_fault      <= fault_d;
      o_lock_lost  <= lock_lost_d;
    end
  end

  // Time in the current state; restarts on every transition and while soft reset is held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_soft_rst || (state_nxt != state)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    if (i_soft_rst) begin
      state_nxt = PLL_RST;
      retry_nxt = '0;
    end else begin
      unique case (state)
        PLL_RST: begin
          if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry_cnt == RETRY_MAX) begin
              state_nxt = FAULT;
            end else begin
              state_nxt = PLL_RST;
              retry_nxt = retry_cnt + 1'b1;
            end
          end
        end
        // A lock drop here is chatter, not a failed attempt: retry count is kept.
        STABLE: begin
          if (!lock_s) begin
            state_nxt = WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = RUN;
            retry_nxt = '0;
          end
        end
        RUN: begin
          if (!lock_s) state_nxt = PLL_RST;
        end
        FAULT: begin
          state_nxt = FAULT;
        end
        default: begin
          state_nxt = PLL_RST;
        end
      endcase
    end
  end

  // Outputs decode the upcoming state so they change together with o_state.
  always_comb begin
    pll_resetb_d = (state_nxt == WAIT_LOCK) || (state_nxt == STABLE) || (state_nxt == RUN);
    sys_rst_n_d  = (state_nxt == RUN);
    fault_d      = (state_nxt == FAULT);
    lock_lost_d  = (state == RUN) && !lock_s && !i_soft_rst;
  end

  assign o_state     = state;
  assign o_retry_cnt = retry_cnt;

endmodule
